// File: rtl/reaction_timer_fsm_pkg.sv
// Shared types for the reaction timer controller: state encoding and the
// LED color triple shown in each state.
package reaction_timer_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RWAIT  = 3'd1,
        TIMING = 3'd2,
        RESULT = 3'd3,
        EARLY  = 3'd4,
        LATE   = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } rgb_t;

    localparam rgb_t COLOR_IDLE   = '{r: 3'd0, g: 3'd0, b: 3'd3};
    localparam rgb_t COLOR_RWAIT  = '{r: 3'd0, g: 3'd0, b: 3'd0};
    localparam rgb_t COLOR_TIMING = '{r: 3'd7, g: 3'd7, b: 3'd7};
    localparam rgb_t COLOR_RESULT = '{r: 3'd0, g: 3'd7, b: 3'd0};
    localparam rgb_t COLOR_EARLY  = '{r: 3'd7, g: 3'd0, b: 3'd0};
    localparam rgb_t COLOR_LATE   = '{r: 3'd7, g: 3'd7, b: 3'd0};

    function automatic rgb_t state_color(input state_t s);
        case (s)
            IDLE:    return COLOR_IDLE;
            RWAIT:   return COLOR_RWAIT;
            TIMING:  return COLOR_TIMING;
            RESULT:  return COLOR_RESULT;
            EARLY:   return COLOR_EARLY;
            LATE:    return COLOR_LATE;
            default: return COLOR_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/reaction_timer_fsm.sv
// Reaction timer sequencer: launches the random wait, times the user's
// response and drives the penalty timer and the status LED.
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | waiting for start, blue LED
// RWAIT  | random wait running, LED dark
// TIMING | reaction counter running, LED white
// RESULT | reaction time displayed, LED green
// EARLY  | pressed before the light, 5 s penalty, red
// LATE   | counter limit exceeded, 5 s penalty, yellow
module reaction_timer_fsm
    import reaction_timer_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       RESET,
    input  logic       start,
    input  logic       enter,
    input  logic       rwait_done,
    input  logic       wait5_done,
    input  logic       time_late,
    output logic       start_rwait,
    output logic       start_wait5,
    output logic       time_clr,
    output logic       time_en,
    output logic       rs_en,
    output logic [2:0] color_r,
    output logic [2:0] color_g,
    output logic [2:0] color_b
);

    state_t state;
    state_t state_next;
    rgb_t   color_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RWAIT;
            RWAIT: begin
                if (enter)           state_next = EARLY;
                else if (rwait_done) state_next = TIMING;
            end
            TIMING: begin
                if (enter)          state_next = RESULT;
                else if (time_late) state_next = LATE;
            end
            RESULT:  if (start) state_next = RWAIT;
            EARLY,
            LATE:    if (wait5_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pulses are Mealy so the external timers start in the same cycle as the
    // decision; leaving the source state on the next edge ends the pulse.
    always_comb begin
        start_rwait = 1'b0;
        time_clr    = 1'b0;
        start_wait5 = 1'b0;
        if (!RESET) begin
            start_rwait = (state == IDLE || state == RESULT) && start;
            time_clr    = (state == IDLE || state == RESULT) && start;
            start_wait5 = (state == RWAIT && enter) ||
                          (state == TIMING && !enter && time_late);
        end
    end

    assign color_next = state_color(state_next);

    // Moore outputs are registered from the next state so they line up with
    // the state register without a combinational decode on the outputs.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state   <= IDLE;
            time_en <= 1'b0;
            rs_en   <= 1'b0;
            color_r <= COLOR_IDLE.r;
            color_g <= COLOR_IDLE.g;
            color_b <= COLOR_IDLE.b;
        end else begin
            state   <= state_next;
            time_en <= (state_next == TIMING);
            rs_en   <= (state_next == RESULT);
            color_r <= color_next.r;
            color_g <= color_next.g;
            color_b <= color_next.b;
        end
    end

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Scoreboard bench for reaction_timer_fsm: a reference state model pushes the
// expected pulses and state outputs, which are popped against the DUT.
module tb_reaction_timer_fsm;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       start = 1'b0;
    logic       enter = 1'b0;
    logic       rwait_done = 1'b0;
    logic       wait5_done = 1'b0;
    logic       time_late = 1'b0;
    logic       start_rwait;
    logic       start_wait5;
    logic       time_clr;
    logic       time_en;
    logic       rs_en;
    logic [2:0] color_r;
    logic [2:0] color_g;
    logic [2:0] color_b;

    reaction_timer_fsm dut (
        .clk         (clk),
        .RESET       (RESET),
        .start       (start),
        .enter       (enter),
        .rwait_done  (rwait_done),
        .wait5_done  (wait5_done),
        .time_late   (time_late),
        .start_rwait (start_rwait),
        .start_wait5 (start_wait5),
        .time_clr    (time_clr),
        .time_en     (time_en),
        .rs_en       (rs_en),
        .color_r     (color_r),
        .color_g     (color_g),
        .color_b     (color_b)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE   = 0;
    localparam int M_RWAIT  = 1;
    localparam int M_TIMING = 2;
    localparam int M_RESULT = 3;
    localparam int M_EARLY  = 4;
    localparam int M_LATE   = 5;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   m_state = M_IDLE;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {time_en, rs_en, r, g, b}
    function automatic logic [31:0] moore_of(input int s);
        case (s)
            M_IDLE:   return {21'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd3};
            M_RWAIT:  return {21'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0};
            M_TIMING: return {21'd0, 1'b1, 1'b0, 3'd7, 3'd7, 3'd7};
            M_RESULT: return {21'd0, 1'b0, 1'b1, 3'd0, 3'd7, 3'd0};
            M_EARLY:  return {21'd0, 1'b0, 1'b0, 3'd7, 3'd0, 3'd0};
            default:  return {21'd0, 1'b0, 1'b0, 3'd7, 3'd7, 3'd0};
        endcase
    endfunction

    task automatic step(input string tag, input logic r, input logic s, input logic e,
                        input logic rd, input logic w5, input logic tl);
        exp_t ex;
        exp_t got;
        logic sr;
        logic sw;
        int   nxt;
        RESET = r; start = s; enter = e; rwait_done = rd; wait5_done = w5; time_late = tl;

        sr = !r && (m_state == M_IDLE || m_state == M_RESULT) && s;
        sw = !r && ((m_state == M_RWAIT && e) || (m_state == M_TIMING && !e && tl));
        ex.tag = {tag, "/pulse"};
        ex.val = {29'd0, sr, sr, sw};
        q.push_back(ex);

        nxt = m_state;
        if (r) nxt = M_IDLE;
        else if (m_state == M_IDLE && s) nxt = M_RWAIT;
        else if (m_state == M_RESULT && s) nxt = M_RWAIT;
        else if (m_state == M_RWAIT && e) nxt = M_EARLY;
        else if (m_state == M_RWAIT && rd) nxt = M_TIMING;
        else if (m_state == M_TIMING && e) nxt = M_RESULT;
        else if (m_state == M_TIMING && tl) nxt = M_LATE;
        else if ((m_state == M_EARLY || m_state == M_LATE) && w5) nxt = M_IDLE;

        #2;
        got = q.pop_front();
        check(got.tag, {29'd0, start_rwait, time_clr, start_wait5}, got.val);

        ex.tag = {tag, "/state_out"};
        ex.val = moore_of(nxt);
        q.push_back(ex);
        @(posedge clk);
        m_state = nxt;
        #1;
        got = q.pop_front();
        check(got.tag, {21'd0, time_en, rs_en, color_r, color_g, color_b}, got.val);
    endtask

    initial begin
        @(posedge clk);
        #1;
        //    tag             rst s  e  rd w5 tl
        step("reset0",        1, 0, 0, 0, 0, 0);
        step("reset1",        1, 1, 1, 1, 1, 1);
        step("idle_hold",     0, 0, 1, 1, 1, 1);
        step("idle_start",    0, 1, 0, 0, 0, 0);
        step("rwait_start",   0, 1, 0, 0, 1, 1);
        step("rwait_hold",    0, 0, 0, 0, 0, 0);
        step("rwait_done",    0, 0, 0, 1, 0, 0);
        step("timing_hold",   0, 1, 0, 0, 1, 0);
        step("timing_enter",  0, 0, 1, 0, 0, 0);
        step("result_enter",  0, 0, 1, 0, 0, 0);
        step("result_start",  0, 1, 0, 0, 0, 0);
        step("rwait_enter",   0, 0, 1, 0, 0, 0);
        step("early_held",    0, 1, 1, 0, 0, 0);
        step("early_w5",      0, 0, 0, 0, 1, 0);
        step("idle_start2",   0, 1, 0, 0, 0, 0);
        step("rwait_done2",   0, 0, 0, 1, 0, 0);
        step("timing_late",   0, 0, 0, 0, 0, 1);
        step("late_hold",     0, 1, 1, 1, 0, 1);
        step("late_w5",       0, 0, 0, 0, 1, 0);
        step("idle_start3",   0, 1, 0, 0, 0, 0);
        step("rwait_both",    0, 0, 1, 1, 0, 0);
        step("early_w5b",     0, 0, 0, 0, 1, 0);
        step("idle_start4",   0, 1, 0, 0, 0, 0);
        step("rwait_done4",   0, 0, 0, 1, 0, 0);
        step("timing_both",   0, 0, 1, 0, 0, 1);
        step("result_start4", 0, 1, 0, 0, 0, 0);
        step("rwait_done5",   0, 0, 0, 1, 0, 0);
        step("timing_reset",  1, 1, 1, 0, 0, 1);
        step("after_reset",   0, 0, 0, 0, 0, 0);
        step("idle_start6",   0, 1, 0, 0, 0, 0);
        step("rwait_done6",   0, 0, 0, 1, 0, 0);
        step("timing_late6",  0, 0, 0, 0, 0, 1);
        step("late_reset",    1, 0, 0, 0, 0, 0);
        step("idle_final",    0, 0, 0, 0, 0, 0);

        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
